// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBreakWait
    } rx_state_t;

    // Error flag bit positions inside a stored FIFO entry's flag field.
    localparam int unsigned ERR_PARITY = 0;
    localparam int unsigned ERR_FRAME  = 1;
    localparam int unsigned ERR_BREAK  = 2;
    localparam int unsigned NUM_ERR    = 3;

    // Per-character framing captured at start-bit detection.
    typedef struct packed {
        logic [3:0] nbits;
        logic       use_par;
        logic       par_odd;
        logic       two_stop;
    } rx_cfg_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_with_clear.sv
// First-word-fall-through synchronous FIFO with a synchronous flush.
module sync_fifo_fwft_with_clear #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver: oversampled majority-vote bit recovery, per-character error
// flags, break detection, receive timeout and an RX FIFO with level tracking.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned TIMEOUT_BITS  = 40,
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_os_strb,
    input  logic [2:0]               i_data_bits,
    input  logic                     i_use_parity,
    input  logic                     i_parity,
    input  logic                     i_stop_bits,
    input  logic [LVL_W-1:0]         i_threshold,
    input  logic                     i_timeout_en,
    input  logic                     i_fifo_clear,
    input  logic                     i_fifo_rd_en,
    output logic [MAX_DATA_BITS-1:0] o_fifo_rd_data,
    output logic [2:0]               o_fifo_rd_err,
    output logic                     o_fifo_full,
    output logic                     o_fifo_empty,
    output logic [LVL_W-1:0]         o_fifo_level,
    output logic                     o_threshold,
    output logic                     o_timeout,
    output logic                     o_overflow_error,
    output logic                     o_underflow_error,
    output logic                     o_busy,
    input  logic                     i_uart_rx
);

    localparam int unsigned CNT_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned ENTRY_W   = MAX_DATA_BITS + NUM_ERR;
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    logic                     rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]               samp_q;
    rx_state_t                state_q, state_d;
    logic [CNT_W-1:0]         os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     par_q, par_d;
    logic                     zero_q, zero_d;
    logic                     par_err_q, par_err_d;
    rx_cfg_t                  cfg_q, cfg_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     thr_q;
    logic                     ovf_q, unf_q;
    logic [TMO_W-1:0]         tmo_q, tmo_d;

    logic                     mid, bnd, vote, start_edge, start_det, brk;
    logic [3:0]               nbits_req;
    logic                     wr_req, wr_ok, rd_ok;
    logic [NUM_ERR-1:0]       wr_flags;
    logic [ENTRY_W-1:0]       wr_entry, rd_entry;
    logic                     fifo_full, fifo_empty;

    assign mid        = i_os_strb && (os_cnt_q == CNT_W'(OVERSAMPLE / 2 + 1));
    assign bnd        = i_os_strb && (os_cnt_q == CNT_W'(OVERSAMPLE - 1));
    // Vote window: two stored samples plus the one arriving on this tick.
    assign vote       = majority3({samp_q, rx_sync_q});
    assign start_edge = rx_prev_q & ~rx_sync_q;
    assign nbits_req  = 4'd5 + {1'b0, i_data_bits};

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        zero_d    = zero_q;
        par_err_d = par_err_q;
        cfg_d     = cfg_q;
        wr_req    = 1'b0;
        wr_flags  = '0;
        start_det = 1'b0;
        brk       = 1'b0;

        if (i_os_strb) begin
            os_cnt_d = bnd ? '0 : os_cnt_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    start_det      = 1'b1;
                    os_cnt_d       = '0;
                    cfg_d.nbits    = (nbits_req > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS)
                                                                      : nbits_req;
                    cfg_d.use_par  = i_use_parity;
                    cfg_d.par_odd  = i_parity;
                    cfg_d.two_stop = i_stop_bits;
                    bit_cnt_d      = '0;
                    data_d         = '0;
                    par_d          = 1'b0;
                    zero_d         = 1'b1;
                    par_err_d      = 1'b0;
                    state_d        = StStart;
                end
            end
            StStart: begin
                if (mid && vote) begin
                    state_d = StIdle;
                end else if (bnd) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mid) begin
                    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                        if (bit_cnt_q == BIT_W'(i)) begin
                            data_d[i] = vote;
                        end
                    end
                    par_d     = par_q ^ vote;
                    zero_d    = zero_q & ~vote;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                if (bnd && (bit_cnt_q == cfg_q.nbits)) begin
                    state_d = cfg_q.use_par ? StParity : StStop1;
                end
            end
            StParity: begin
                if (mid) begin
                    par_err_d = vote ^ par_q ^ cfg_q.par_odd;
                    zero_d    = zero_q & ~vote;
                end
                if (bnd) begin
                    state_d = StStop1;
                end
            end
            StStop1: begin
                if (mid) begin
                    brk                  = zero_q & ~vote;
                    wr_req               = 1'b1;
                    wr_flags[ERR_PARITY] = par_err_q;
                    wr_flags[ERR_FRAME]  = ~vote;
                    wr_flags[ERR_BREAK]  = brk;
                    if (brk) begin
                        state_d = StBreakWait;
                    end else if (cfg_q.two_stop) begin
                        state_d = StStop2;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StStop2: begin
                // Entry already stored at STOP1, so a bad second stop bit is not recorded.
                if (mid) begin
                    state_d = StIdle;
                end
            end
            StBreakWait: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_entry = {wr_flags, data_q};
    assign rd_ok    = i_fifo_rd_en & ~fifo_empty;
    assign wr_ok    = wr_req & (~fifo_full | rd_ok);

    always_comb begin
        level_d = level_q;
        if (i_fifo_clear) begin
            level_d = '0;
        end else begin
            level_d = level_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (wr_req || i_fifo_rd_en || i_fifo_clear || start_det || !i_timeout_en) begin
            tmo_d = '0;
        end else if (i_os_strb && !fifo_empty && (state_q == StIdle) &&
                     (tmo_q != TMO_W'(TMO_LIMIT))) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            samp_q    <= 2'b11;
            state_q   <= StIdle;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            zero_q    <= 1'b0;
            par_err_q <= 1'b0;
            cfg_q     <= '0;
            level_q   <= '0;
            thr_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (i_os_strb) begin
                samp_q <= {samp_q[0], rx_sync_q};
            end
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            zero_q    <= zero_d;
            par_err_q <= par_err_d;
            cfg_q     <= cfg_d;
            level_q   <= level_d;
            thr_q     <= (level_q >= i_threshold);
            ovf_q     <= wr_req & ~wr_ok & ~i_fifo_clear;
            unf_q     <= i_fifo_rd_en & fifo_empty & ~i_fifo_clear;
            tmo_q     <= tmo_d;
        end
    end

    sync_fifo_fwft_with_clear #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (i_fifo_clear),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (i_fifo_rd_en),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_fifo_rd_data    = rd_entry[MAX_DATA_BITS-1:0];
    assign o_fifo_rd_err     = rd_entry[ENTRY_W-1:MAX_DATA_BITS];
    assign o_fifo_full       = fifo_full;
    assign o_fifo_empty      = fifo_empty;
    assign o_fifo_level      = level_q;
    assign o_threshold       = thr_q;
    assign o_timeout         = (tmo_q == TMO_W'(TMO_LIMIT));
    assign o_overflow_error  = ovf_q;
    assign o_underflow_error = unf_q;
    assign o_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framing, errors, glitches, break, FIFO and timeout.
module tb_uart_rx_os;

    logic       clk;
    logic       rst_n;
    logic       os_strb;
    logic [2:0] data_bits;
    logic       use_parity;
    logic       parity;
    logic       stop_bits;
    logic [4:0] threshold;
    logic       timeout_en;
    logic       fifo_clear;
    logic       fifo_rd_en;
    logic [8:0] fifo_rd_data;
    logic [2:0] fifo_rd_err;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_level;
    logic       thr;
    logic       tmo;
    logic       ovf;
    logic       unf;
    logic       busy;
    logic       uart_rx;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_cnt  = 0;
    int unf_cnt  = 0;

    uart_rx_os u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_os_strb         (os_strb),
        .i_data_bits       (data_bits),
        .i_use_parity      (use_parity),
        .i_parity          (parity),
        .i_stop_bits       (stop_bits),
        .i_threshold       (threshold),
        .i_timeout_en      (timeout_en),
        .i_fifo_clear      (fifo_clear),
        .i_fifo_rd_en      (fifo_rd_en),
        .o_fifo_rd_data    (fifo_rd_data),
        .o_fifo_rd_err     (fifo_rd_err),
        .o_fifo_full       (fifo_full),
        .o_fifo_empty      (fifo_empty),
        .o_fifo_level      (fifo_level),
        .o_threshold       (thr),
        .o_timeout         (tmo),
        .o_overflow_error  (ovf),
        .o_underflow_error (unf),
        .o_busy            (busy),
        .i_uart_rx         (uart_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock oversample tick every fourth clock.
    initial begin
        os_strb = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 os_strb = 1'b1;
            @(posedge clk);
            #1 os_strb = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (ovf === 1'b1) ovf_cnt <= ovf_cnt + 1;
        if (unf === 1'b1) unf_cnt <= unf_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strb(input int n);
        repeat (n) begin
            do @(posedge clk); while (os_strb !== 1'b1);
        end
        #1;
    endtask

    // One bit period; optionally invert the line for the single mid-bit tick.
    task automatic line_bit(input logic b, input bit glitch);
        uart_rx = b;
        if (glitch) begin
            wait_strb(8);
            uart_rx = ~b;
            wait_strb(1);
            uart_rx = b;
            wait_strb(7);
        end else begin
            wait_strb(16);
        end
    endtask

    task automatic send_char(input logic [8:0] d, input int nbits, input bit pen,
                             input bit podd, input bit pwrong, input logic stop1,
                             input bit two, input bit glitch);
        logic p;
        p = podd;
        line_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            line_bit(d[i], glitch);
            p = p ^ d[i];
        end
        if (pen) line_bit(p ^ pwrong, 1'b0);
        line_bit(stop1, 1'b0);
        if (two) line_bit(1'b1, 1'b0);
    endtask

    task automatic pop();
        fifo_rd_en = 1'b1;
        @(posedge clk);
        #1 fifo_rd_en = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        uart_rx    = 1'b1;
        data_bits  = 3'd3;
        use_parity = 1'b0;
        parity     = 1'b0;
        stop_bits  = 1'b0;
        threshold  = 5'd1;
        timeout_en = 1'b0;
        fifo_clear = 1'b0;
        fifo_rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_empty", 32'(fifo_empty), 1);
        check_eq("rst_full", 32'(fifo_full), 0);
        check_eq("rst_level", 32'(fifo_level), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_outs", 32'({thr, tmo, ovf, unf, fifo_rd_err, fifo_rd_data}), 0);
        rst_n = 1'b1;
        wait_strb(20);
        check_eq("idle_thr", 32'(thr), 0);

        // 8N1 0xA5
        send_char(9'h0A5, 8, 0, 0, 0, 1'b1, 0, 0);
        check_eq("a5_level", 32'(fifo_level), 1);
        check_eq("a5_data", 32'(fifo_rd_data), 32'h0A5);
        check_eq("a5_err", 32'(fifo_rd_err), 0);
        check_eq("a5_thr", 32'(thr), 1);
        pop();
        @(posedge clk);
        #1;
        check_eq("a5_pop_empty", 32'(fifo_empty), 1);
        check_eq("a5_thr_fall", 32'(thr), 0);

        // 9O1, 0x1FF with wrong parity
        data_bits  = 3'd4;
        use_parity = 1'b1;
        parity     = 1'b1;
        send_char(9'h1FF, 9, 1, 1, 1, 1'b1, 0, 0);
        check_eq("par_data", 32'(fifo_rd_data), 32'h1FF);
        check_eq("par_err", 32'(fifo_rd_err), 1);
        pop();

        // 7E2, first stop bit low
        data_bits = 3'd2;
        parity    = 1'b0;
        stop_bits = 1'b1;
        send_char(9'h035, 7, 1, 0, 0, 1'b0, 1, 0);
        wait_strb(4);
        check_eq("frm_data", 32'(fifo_rd_data), 32'h035);
        check_eq("frm_err", 32'(fifo_rd_err), 2);
        check_eq("frm_busy", 32'(busy), 0);
        pop();

        // False start: 6 low ticks
        data_bits  = 3'd3;
        use_parity = 1'b0;
        stop_bits  = 1'b0;
        uart_rx = 1'b0;
        wait_strb(6);
        uart_rx = 1'b1;
        wait_strb(16);
        check_eq("glitch_busy", 32'(busy), 0);
        check_eq("glitch_level", 32'(fifo_level), 0);

        // Mid-bit glitch on every data bit
        send_char(9'h03C, 8, 0, 0, 0, 1'b1, 0, 1);
        check_eq("maj_data", 32'(fifo_rd_data), 32'h03C);
        check_eq("maj_err", 32'(fifo_rd_err), 0);
        pop();

        // Break: 20 bit times low
        uart_rx = 1'b0;
        wait_strb(16 * 20);
        check_eq("brk_busy_low", 32'(busy), 1);
        check_eq("brk_level", 32'(fifo_level), 1);
        uart_rx = 1'b1;
        wait_strb(2);
        check_eq("brk_busy_high", 32'(busy), 0);
        check_eq("brk_level_after", 32'(fifo_level), 1);
        check_eq("brk_data", 32'(fifo_rd_data), 0);
        check_eq("brk_err", 32'(fifo_rd_err), 6);
        pop();

        // Timeout: 3 chars, 640 ticks after the last write (written at tick 9 of
        // the stop bit, so 6 ticks already elapsed when send_char returns)
        timeout_en = 1'b1;
        send_char(9'h011, 8, 0, 0, 0, 1'b1, 0, 0);
        send_char(9'h022, 8, 0, 0, 0, 1'b1, 0, 0);
        send_char(9'h033, 8, 0, 0, 0, 1'b1, 0, 0);
        wait_strb(633);
        check_eq("tmo_639", 32'(tmo), 0);
        wait_strb(1);
        check_eq("tmo_640", 32'(tmo), 1);
        check_eq("tmo_head", 32'(fifo_rd_data), 32'h011);
        pop();
        check_eq("tmo_read_clr", 32'(tmo), 0);
        fifo_clear = 1'b1;
        @(posedge clk);
        #1 fifo_clear = 1'b0;
        check_eq("clr_level", 32'(fifo_level), 0);
        check_eq("clr_empty", 32'(fifo_empty), 1);
        timeout_en = 1'b0;

        // Overflow: 17 chars into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_char(9'(i), 8, 0, 0, 0, 1'b1, 0, 0);
        end
        check_eq("ovf_full", 32'(fifo_full), 1);
        check_eq("ovf_level", 32'(fifo_level), 16);
        check_eq("ovf_pulses", 32'(ovf_cnt), 1);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_data", 32'(fifo_rd_data), 32'(i));
            pop();
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("drain_empty", 32'(fifo_empty), 1);
        check_eq("unf_none", 32'(unf_cnt), 0);
        pop();
        repeat (2) @(posedge clk);
        #1;
        check_eq("unf_pulse", 32'(unf_cnt), 1);
        check_eq("unf_level", 32'(fifo_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Second-generation UART receiver with an internal oversampling bit timer (OVERSAMPLE ticks per bit) and 3-sample majority voting.
- Supports 5..MAX_DATA_BITS data bits.
- Each received character is stored in the RX FIFO together with its own error flags (parity, frame, break).
- Adds false-start rejection, break detection, a receive timeout and a FIFO level output. Sits between the baud generator (oversample tick) and the AXI4-Lite register block.

Parameters:
- FIFO_DEPTH, 16, RX FIFO entries (power of 2, >=4).
- MAX_DATA_BITS, 9, widest supported character (8 or 9).
- OVERSAMPLE, 16, oversample ticks per bit (even, 8..32).
- TIMEOUT_BITS, 40, idle bit periods before o_timeout asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_os_strb  in  1  oversample tick, 1 clk wide, rate = baud*OVERSAMPLE
- i_data_bits  in  3  character length = 5+value; values above MAX_DATA_BITS-5 clamp to MAX_DATA_BITS
- i_use_parity  in  1  parity bit present
- i_parity  in  1  0=even, 1=odd
- i_stop_bits  in  1  0=one stop bit, 1=two
- i_threshold  in  $clog2(FIFO_DEPTH+1)  level threshold
- i_timeout_en  in  1  enable receive timeout
- i_fifo_clear  in  1  synchronous FIFO flush
- i_fifo_rd_en  in  1  pop head entry
- o_fifo_rd_data  out  MAX_DATA_BITS  head data, right-aligned, unused MSBs 0
- o_fifo_rd_err  out  3  head flags {break, frame, parity}
- o_fifo_full / o_fifo_empty  out  1  FIFO status
- o_fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held
- o_threshold  out  1  registered (o_fifo_level >= i_threshold)
- o_timeout  out  1  receive timeout, level
- o_overflow_error / o_underflow_error  out  1  1-clk pulses
- o_busy  out  1  FSM not in IDLE
- i_uart_rx  in  1  asynchronous serial input

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset applies to all flops, including the 2FF synchroniser (resets to 1).
- Reset values: all outputs 0 except o_fifo_empty=1.
- A reset mid-character discards the character; the FIFO is emptied.
- Config latching: all config inputs are latched at start-bit detection and held for the whole character.
- Sampling: synchronised rx is shifted into a 3-bit sample register on each i_os_strb. The bit value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit.
- Tick counter: os_cnt counts 0..OVERSAMPLE-1 on i_os_strb and wraps at the bit boundary.
- FSM state IDLE: on a synchronised 1->0 edge, clear os_cnt and go to START.
- FSM state START: at the mid-bit vote, if the vote is 1 it is a false start: return to IDLE, no write, no flags. Otherwise go to DATA at the bit boundary.
- FSM state DATA: shift in LSB first. After N bits go to PARITY if enabled, else STOP1.
- FSM state PARITY: error if the received parity bit does not match the parity computed over the data bits (even/odd per i_parity).
- FSM state STOP1: frame error if the vote is 0. The entry {flags, data} is written at the STOP1 mid-bit vote, even if flagged.
  - Next state after STOP1:
    - BREAK_WAIT if break is set;
    - else STOP2 if two stop bits;
    - else IDLE.
  - Ending at mid-stop allows back-to-back characters.
- FSM state STOP2: frame error only if STOP1 was good. The second stop bit is checked, but the entry has already been written, so the error is not stored; this is a known limitation. Then go to IDLE.
- Break: all data, parity and stop votes are 0. Write data=0 with flags {1,1,x}.
- FSM state BREAK_WAIT: remain until the synchronised line is 1, then IDLE; no further writes.
- FIFO write when full: the entry is dropped and o_overflow_error pulses the next cycle. Exception: a simultaneous i_fifo_rd_en makes room and the write succeeds.
- FIFO read when empty: ignored; o_underflow_error pulses.
- i_fifo_clear: takes priority over a same-cycle write and read; level becomes 0.
- o_threshold: registered, 1-cycle latency after a level change.
- Timeout counter: counts i_os_strb ticks while i_timeout_en, the FIFO is non-empty and the FSM is IDLE. It resets on any write, read, clear or start detection.
- o_timeout: asserts when the count reaches TIMEOUT_BITS*OVERSAMPLE and holds until the counter resets.

Decomposition:
- uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
  - Flag bit indices: ERR_PARITY=0, ERR_FRAME=1, ERR_BREAK=2.
  - Function majority3.
- Sub-module: reuse the existing sync_fifo_fwft_with_clear at DATA_WIDTH=MAX_DATA_BITS+3. Level is tracked locally.

Test Plan:
- 8N1, OVERSAMPLE=16, byte 0xA5 -> one entry, data 0x0A5, flags 000, o_threshold rises when i_threshold=1.
- 9 data bits, odd parity, value 0x1FF with a wrong parity bit -> data 0x1FF, flags 001. Then 7E2 with the first stop bit low -> flags 010.
- Glitch: rx low for 6 ticks only -> false start, FSM back in IDLE, level stays 0, no flags.
- Majority vote: one-tick inverted glitch at mid-bit on every data bit of 0x3C -> data still 0x3C.
- Break: line held low for 20 bit times, then high -> exactly one entry, data 0, flags 110. o_busy stays 1 until the line returns high.
- FIFO_DEPTH=16: send 17 chars, no reads -> o_fifo_full, 1-clk o_overflow_error, level 16. Read 17 times -> o_underflow_error on the 17th. Timeout with 3 chars left and TIMEOUT_BITS=40 -> o_timeout at 640 ticks after the last write; clears on a read.
